// File: rtl/rvfi_mini_pkg.sv
// Shared definitions for the rvfi_mini core: RV32I opcode and funct3
// encodings, the core FSM state type, and immediate decoding.
package rvfi_mini_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU funct3 (OP / OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {FETCH, EXEC, RETIRE, HALT} state_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    // Sign-extended immediate for the given instruction format.
    function automatic logic [31:0] imm_gen(input logic [31:0] insn, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   imm_gen = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   imm_gen = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   imm_gen = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   imm_gen = {insn[31:12], 12'd0};
            IMM_J:   imm_gen = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm_gen = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/rvfi_mini_alu.sv
// Combinational integer ALU and branch comparator for rvfi_mini_core.
// The same funct3 selects both the arithmetic result and the branch test;
// the caller picks whichever output matches the instruction class.
module rvfi_mini_alu import rvfi_mini_pkg::*; (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    input  logic        alt,
    output logic [31:0] result,
    output logic        br_cond
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Arithmetic/logic result; alt selects SUB and SRA.
    always_comb begin
        result = 32'd0;
        case (funct3)
            F3_ADD:  result = alt ? (a - b) : (a + b);
            F3_SLL:  result = a << shamt;
            F3_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            F3_SLTU: result = {31'd0, a < b};
            F3_XOR:  result = a ^ b;
            F3_SR:   result = alt ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = 32'd0;
        endcase
    end

    // Branch condition for the conditional-branch funct3 encodings.
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            F3_BEQ:  br_cond = (a == b);
            F3_BNE:  br_cond = (a != b);
            F3_BLT:  br_cond = ($signed(a) < $signed(b));
            F3_BGE:  br_cond = ($signed(a) >= $signed(b));
            F3_BLTU: br_cond = (a < b);
            F3_BGEU: br_cond = (a >= b);
            default: br_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/rvfi_mini_core.sv
// Multi-cycle RV32I integer core (no loads/stores) emitting one RVFI
// retire packet per instruction. FETCH -> EXEC -> RETIRE, halting on trap.
// imem handshake: a fetch completes on a cycle where imem_valid && imem_ready;
// imem_addr is held stable while imem_valid waits for imem_ready.
module rvfi_mini_core import rvfi_mini_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        rvfi_valid,
    output logic [31:0] rvfi_insn,
    output logic [4:0]  rvfi_rs1,
    output logic [4:0]  rvfi_rs2,
    output logic [4:0]  rvfi_rd,
    output logic [31:0] rvfi_pre_pc,
    output logic [31:0] rvfi_pre_rs1,
    output logic [31:0] rvfi_pre_rs2,
    output logic [31:0] rvfi_post_pc,
    output logic [31:0] rvfi_post_rd,
    output logic        rvfi_post_trap,
    output state_e      dbg_state
);

    state_e      state;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] regs [1:31];

    assign imem_addr = pc;
    assign dbg_state = state;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_b, imm_u, imm_j, pc_plus4;

    assign opcode   = insn[6:0];
    assign rd_idx   = insn[11:7];
    assign f3       = insn[14:12];
    assign rs1_idx  = insn[19:15];
    assign rs2_idx  = insn[24:20];
    assign f7       = insn[31:25];
    assign rs1_val  = (rs1_idx == 5'd0) ? 32'd0 : regs[rs1_idx];
    assign rs2_val  = (rs2_idx == 5'd0) ? 32'd0 : regs[rs2_idx];
    assign imm_i    = imm_gen(insn, IMM_I);
    assign imm_b    = imm_gen(insn, IMM_B);
    assign imm_u    = imm_gen(insn, IMM_U);
    assign imm_j    = imm_gen(insn, IMM_J);
    assign pc_plus4 = pc + 32'd4;

    logic        illegal, use_rs1, use_rs2, use_rd, is_jump, trap;
    logic        alu_alt, br_cond;
    logic [31:0] alu_b, alu_result, result, next_pc;

    rvfi_mini_alu u_alu (
        .a       (rs1_val),
        .b       (alu_b),
        .funct3  (f3),
        .alt     (alu_alt),
        .result  (alu_result),
        .br_cond (br_cond)
    );

    // Decode the latched instruction into operand usage, result, next PC and trap.
    always_comb begin
        illegal = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        is_jump = 1'b0;
        alu_b   = imm_i;
        alu_alt = 1'b0;
        result  = 32'd0;
        next_pc = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                use_rd = 1'b1;
                result = imm_u;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1;
                result = pc + imm_u;
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                result  = pc_plus4;
                next_pc = pc + imm_j;
                is_jump = 1'b1;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                illegal = (f3 != 3'b000);
                result  = pc_plus4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
                is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = (f3 == 3'b010) || (f3 == 3'b011);
                alu_b   = rs2_val;
                if (br_cond) begin
                    next_pc = pc + imm_b;
                    is_jump = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                if (f3 == F3_SLL) begin
                    illegal = (f7 != F7_ZERO);
                end else if (f3 == F3_SR) begin
                    // bit 25 set would be a 6-bit shamt, not legal on RV32
                    illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
                    alu_alt = insn[30];
                end
                result = alu_result;
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                alu_b   = rs2_val;
                alu_alt = insn[30];
                illegal = !((f7 == F7_ZERO) ||
                            ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
                result  = alu_result;
            end
            default: illegal = 1'b1;
        endcase
        trap = illegal || (is_jump && next_pc[1]);
    end

    // Core FSM: fetch handshake, register the retire packet, commit PC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            insn           <= 32'd0;
            imem_valid     <= 1'b0;
            rvfi_valid     <= 1'b0;
            rvfi_insn      <= 32'd0;
            rvfi_rs1       <= 5'd0;
            rvfi_rs2       <= 5'd0;
            rvfi_rd        <= 5'd0;
            rvfi_pre_pc    <= 32'd0;
            rvfi_pre_rs1   <= 32'd0;
            rvfi_pre_rs2   <= 32'd0;
            rvfi_post_pc   <= 32'd0;
            rvfi_post_rd   <= 32'd0;
            rvfi_post_trap <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_valid) begin
                        imem_valid <= 1'b1;
                    end else if (imem_ready) begin
                        insn       <= imem_rdata;
                        imem_valid <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rvfi_valid     <= 1'b1;
                    rvfi_insn      <= insn;
                    rvfi_rs1       <= use_rs1 ? rs1_idx : 5'd0;
                    rvfi_rs2       <= use_rs2 ? rs2_idx : 5'd0;
                    rvfi_rd        <= (use_rd && !trap) ? rd_idx : 5'd0;
                    rvfi_pre_pc    <= pc;
                    rvfi_pre_rs1   <= use_rs1 ? rs1_val : 32'd0;
                    rvfi_pre_rs2   <= use_rs2 ? rs2_val : 32'd0;
                    rvfi_post_pc   <= trap ? pc : next_pc;
                    rvfi_post_rd   <= (use_rd && !trap && (rd_idx != 5'd0)) ? result : 32'd0;
                    rvfi_post_trap <= trap;
                    state          <= RETIRE;
                end
                RETIRE: begin
                    rvfi_valid <= 1'b0;
                    if (rvfi_post_trap) begin
                        state <= HALT;
                    end else begin
                        pc         <= rvfi_post_pc;
                        imem_valid <= 1'b1;
                        state      <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= HALT;
            endcase
        end
    end

    // Register file write at the end of RETIRE; x0 is never stored.
    always_ff @(posedge clk) begin
        if (state == RETIRE && !rvfi_post_trap && rvfi_rd != 5'd0) begin
            regs[rvfi_rd] <= rvfi_post_rd;
        end
    end

endmodule

// File: tb/tb_rvfi_mini_core.sv
// Directed self-checking bench for rvfi_mini_core.
module tb_rvfi_mini_core;
    import rvfi_mini_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic        rvfi_valid;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rs1, rvfi_rs2, rvfi_rd;
    logic [31:0] rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd;
    logic        rvfi_post_trap;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:15];
    assign imem_rdata = mem[imem_addr[5:2]];

    always #5 clk = ~clk;

    rvfi_mini_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .resetn(resetn),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_rs1(rvfi_rs1), .rvfi_rs2(rvfi_rs2), .rvfi_rd(rvfi_rd),
        .rvfi_pre_pc(rvfi_pre_pc), .rvfi_pre_rs1(rvfi_pre_rs1), .rvfi_pre_rs2(rvfi_pre_rs2),
        .rvfi_post_pc(rvfi_post_pc), .rvfi_post_rd(rvfi_post_rd),
        .rvfi_post_trap(rvfi_post_trap), .dbg_state(dbg_state)
    );

    // ---- driver tasks ----
    task automatic fill_nops();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic reset_pulse();
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_retire(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < budget && !ok) begin
            @(posedge clk); #1;
            cycles++;
            if (rvfi_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // ---- tests ----
    task automatic test_reset();
        fill_nops();
        mem[0] = 32'h0050_0093; // ADDI x1,x0,5
        mem[1] = 32'h0070_0113; // ADDI x2,x0,7
        mem[2] = 32'h0020_81B3; // ADD  x3,x1,x2
        mem[3] = 32'h0000_0013; // NOP
        mem[4] = 32'h0000_0463; // BEQ  x0,x0,+8 at 0x10
        mem[5] = 32'h0000_0013;
        mem[6] = 32'h0000_0000; // illegal at 0x18
        imem_ready = 1'b1;
        @(negedge clk); resetn = 1'b0;
        @(negedge clk);
        checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL reset_rvfi_valid: got %b want 0", rvfi_valid); end
        checks++; if ({rvfi_insn, rvfi_post_pc, rvfi_post_rd, rvfi_pre_pc} !== 128'd0) begin errors++; $display("FAIL reset_rvfi_words: insn=%h post_pc=%h post_rd=%h pre_pc=%h want 0", rvfi_insn, rvfi_post_pc, rvfi_post_rd, rvfi_pre_pc); end
        checks++; if ({rvfi_rs1, rvfi_rs2, rvfi_rd, rvfi_post_trap, rvfi_pre_rs1, rvfi_pre_rs2} !== 80'd0) begin errors++; $display("FAIL reset_rvfi_regs: rs1=%0d rs2=%0d rd=%0d trap=%b want 0", rvfi_rs1, rvfi_rs2, rvfi_rd, rvfi_post_trap); end
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL reset_imem_valid: got %b want 0", imem_valid); end
        checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL reset_state: got %0d want FETCH", dbg_state); end
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_fetch: valid=%b addr=%h want 1/00000000", imem_valid, imem_addr); end
    endtask

    // Continues the program loaded by test_reset; one cycle already elapsed.
    task automatic test_program();
        int c; bit ok;
        wait_retire(20, c, ok);
        checks++; if (!ok || c != 2) begin errors++; $display("FAIL addi_latency: got %0d more cycles (seen=%0d) want 2", c, ok); end
        checks++; if (rvfi_rs1 !== 5'd0 || rvfi_rs2 !== 5'd0 || rvfi_rd !== 5'd1) begin errors++; $display("FAIL addi_idx: rs1=%0d rs2=%0d rd=%0d want 0/0/1", rvfi_rs1, rvfi_rs2, rvfi_rd); end
        checks++; if (rvfi_post_rd !== 32'd5 || rvfi_post_pc !== 32'h4 || rvfi_post_trap !== 1'b0) begin errors++; $display("FAIL addi_result: post_rd=%h post_pc=%h trap=%b want 5/4/0", rvfi_post_rd, rvfi_post_pc, rvfi_post_trap); end
        wait_retire(20, c, ok);
        checks++; if (!ok || c != 3 || rvfi_post_rd !== 32'd7) begin errors++; $display("FAIL back_to_back: cycles=%0d post_rd=%h want 3/7", c, rvfi_post_rd); end
        wait_retire(20, c, ok);
        checks++; if (!ok || rvfi_pre_rs1 !== 32'd5 || rvfi_pre_rs2 !== 32'd7) begin errors++; $display("FAIL add_operands: pre_rs1=%h pre_rs2=%h want 5/7", rvfi_pre_rs1, rvfi_pre_rs2); end
        checks++; if (rvfi_rs1 !== 5'd1 || rvfi_rs2 !== 5'd2 || rvfi_rd !== 5'd3 || rvfi_post_rd !== 32'd12) begin errors++; $display("FAIL add_result: rs1=%0d rs2=%0d rd=%0d post_rd=%h want 1/2/3/c", rvfi_rs1, rvfi_rs2, rvfi_rd, rvfi_post_rd); end
        @(posedge clk); #1;
        checks++; if (rvfi_valid !== 1'b0 || rvfi_post_rd !== 32'd12 || rvfi_rd !== 5'd3) begin errors++; $display("FAIL hold_fields: valid=%b post_rd=%h rd=%0d want 0/c/3", rvfi_valid, rvfi_post_rd, rvfi_rd); end
        wait_retire(20, c, ok);
        checks++; if (!ok || rvfi_rd !== 5'd0 || rvfi_post_rd !== 32'd0 || rvfi_post_pc !== 32'h10) begin errors++; $display("FAIL nop_x0: rd=%0d post_rd=%h post_pc=%h want 0/0/10", rvfi_rd, rvfi_post_rd, rvfi_post_pc); end
        wait_retire(20, c, ok);
        checks++; if (!ok || rvfi_pre_pc !== 32'h10 || rvfi_rd !== 5'd0 || rvfi_post_pc !== 32'h18 || rvfi_post_trap !== 1'b0) begin errors++; $display("FAIL beq_taken: pre_pc=%h rd=%0d post_pc=%h trap=%b want 10/0/18/0", rvfi_pre_pc, rvfi_rd, rvfi_post_pc, rvfi_post_trap); end
        wait_retire(20, c, ok);
        checks++; if (!ok || rvfi_post_trap !== 1'b1 || rvfi_pre_pc !== 32'h18 || rvfi_post_pc !== 32'h18) begin errors++; $display("FAIL illegal_trap: trap=%b pre_pc=%h post_pc=%h want 1/18/18", rvfi_post_trap, rvfi_pre_pc, rvfi_post_pc); end
        checks++; if (rvfi_rd !== 5'd0 || rvfi_post_rd !== 32'd0) begin errors++; $display("FAIL illegal_rd: rd=%0d post_rd=%h want 0/0", rvfi_rd, rvfi_post_rd); end
        begin
            bit activity = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (imem_valid !== 1'b0 || rvfi_valid !== 1'b0) activity = 1'b1;
            end
            checks++; if (activity || dbg_state !== HALT) begin errors++; $display("FAIL halt_quiet: activity=%b state=%0d want 0/HALT", activity, dbg_state); end
        end
    endtask

    task automatic test_trap_jal();
        int c; bit ok;
        fill_nops();
        mem[0] = 32'h0090_0093; // ADDI x1,x0,9
        mem[1] = 32'h0060_00EF; // JAL x1,+6 -> target 0xA, misaligned
        imem_ready = 1'b1;
        reset_pulse();
        wait_retire(20, c, ok);
        checks++; if (!ok || c != 3 || rvfi_post_rd !== 32'd9) begin errors++; $display("FAIL jal_setup: cycles=%0d post_rd=%h want 3/9", c, rvfi_post_rd); end
        wait_retire(20, c, ok);
        checks++; if (!ok || rvfi_post_trap !== 1'b1 || rvfi_post_pc !== 32'h4 || rvfi_pre_pc !== 32'h4) begin errors++; $display("FAIL jal_trap: trap=%b pre_pc=%h post_pc=%h want 1/4/4", rvfi_post_trap, rvfi_pre_pc, rvfi_post_pc); end
        checks++; if (rvfi_rd !== 5'd0 || rvfi_post_rd !== 32'd0 || rvfi_rs1 !== 5'd0 || rvfi_rs2 !== 5'd0) begin errors++; $display("FAIL jal_trap_fields: rd=%0d post_rd=%h rs1=%0d rs2=%0d want 0", rvfi_rd, rvfi_post_rd, rvfi_rs1, rvfi_rs2); end
        repeat (6) @(posedge clk); #1;
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL jal_halt: imem_valid=%b want 0", imem_valid); end
        // register file survives reset, so x1 can be read back by a new program
        mem[0] = 32'h0000_8113; // ADDI x2,x1,0
        reset_pulse();
        wait_retire(20, c, ok);
        checks++; if (!ok || rvfi_pre_rs1 !== 32'd9 || rvfi_post_rd !== 32'd9) begin errors++; $display("FAIL jal_x1_kept: pre_rs1=%h post_rd=%h want 9/9", rvfi_pre_rs1, rvfi_post_rd); end
    endtask

    task automatic test_alu();
        int c; bit ok;
        logic [31:0] a_addr [0:8];
        logic [31:0] a_insn [0:8];
        logic [4:0]  e_rd   [0:8];
        logic [31:0] e_val  [0:8];
        logic [31:0] e_pc   [0:8];
        logic        e_trap [0:8];
        a_addr = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h24};
        a_insn = '{32'hFFD0_0213, 32'h4012_5293, 32'h0052_2333, 32'h4040_03B3, 32'h01C2_5413,
                   32'h1234_54B7, 32'h0000_1517, 32'h0250_05E7, 32'h0202_1013};
        e_rd   = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd0};
        e_val  = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd1, 32'd3, 32'hF, 32'h1234_5000, 32'h1018, 32'h20, 32'd0};
        e_pc   = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h24, 32'h24};
        e_trap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        fill_nops();
        for (int i = 0; i < 9; i++) mem[a_addr[i][5:2]] = a_insn[i];
        imem_ready = 1'b1;
        reset_pulse();
        for (int i = 0; i < 9; i++) begin
            wait_retire(20, c, ok);
            checks++;
            if (!ok || rvfi_pre_pc !== a_addr[i] || rvfi_rd !== e_rd[i] || rvfi_post_rd !== e_val[i] ||
                rvfi_post_pc !== e_pc[i] || rvfi_post_trap !== e_trap[i]) begin
                errors++;
                $display("FAIL alu_vec%0d: pre_pc=%h rd=%0d post_rd=%h post_pc=%h trap=%b want %h/%0d/%h/%h/%b",
                         i, rvfi_pre_pc, rvfi_rd, rvfi_post_rd, rvfi_post_pc, rvfi_post_trap,
                         a_addr[i], e_rd[i], e_val[i], e_pc[i], e_trap[i]);
            end
        end
    endtask

    task automatic test_wait_ready();
        int c; bit ok; bit unstable;
        fill_nops();
        mem[0] = 32'h0050_0093;
        imem_ready = 1'b0;
        reset_pulse();
        unstable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (imem_valid !== 1'b1 || imem_addr !== 32'h0 || rvfi_valid !== 1'b0) unstable = 1'b1;
        end
        checks++; if (unstable) begin errors++; $display("FAIL wait_stable: valid=%b addr=%h rvfi_valid=%b want 1/0/0", imem_valid, imem_addr, rvfi_valid); end
        imem_ready = 1'b1;
        wait_retire(20, c, ok);
        checks++; if (!ok || (c + 4) != 6 || rvfi_post_rd !== 32'd5) begin errors++; $display("FAIL wait_latency: cycles=%0d post_rd=%h want 6/5", c + 4, rvfi_post_rd); end
    endtask

    task automatic test_reset_mid_fetch();
        int c; bit ok;
        fill_nops();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0000_0000;
        imem_ready = 1'b0;
        reset_pulse();
        @(posedge clk); #1;
        checks++; if (imem_valid !== 1'b1) begin errors++; $display("FAIL midfetch_req: imem_valid=%b want 1", imem_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (imem_valid !== 1'b0 || rvfi_valid !== 1'b0) begin errors++; $display("FAIL midfetch_drop: imem_valid=%b rvfi_valid=%b want 0/0", imem_valid, rvfi_valid); end
        @(negedge clk); resetn = 1'b1; imem_ready = 1'b1;
        wait_retire(20, c, ok);
        checks++; if (!ok || c != 3 || rvfi_pre_pc !== 32'h0 || rvfi_insn !== 32'h0050_0093) begin errors++; $display("FAIL midfetch_restart: cycles=%0d pre_pc=%h insn=%h want 3/0/00500093", c, rvfi_pre_pc, rvfi_insn); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_trap_jal();
        test_alu();
        test_wait_ready();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_mini_core.md
# rvfi_mini_core

Small multi-cycle RV32I integer core that produces a single-channel RVFI retire stream (NRET=1). It is the producer end of the per-instruction checker interface: each retired instruction emits exactly one RVFI packet, formatted for direct connection to the checker. It serves as a known-good DUT for bringing up checker harnesses and supports no memory instructions.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk, input, 1, sole clock; all state on rising edge.
- resetn, input, 1, asynchronous active-low reset.
- imem_valid, output, 1, fetch request.
- imem_addr, output, 32, fetch address (word aligned).
- imem_ready, input, 1, fetch completes this cycle.
- imem_rdata, input, 32, instruction word; sampled when imem_valid && imem_ready.
- rvfi_valid, output, 1, one-cycle retire pulse.
- rvfi_insn, output, 32, retired instruction word.
- rvfi_rs1 / rvfi_rs2, output, 5 each, source register indices; 0 if the operand is unused.
- rvfi_rd, output, 5, destination index; 0 if there is no write or rd is x0.
- rvfi_pre_pc, output, 32, PC of the retired instruction.
- rvfi_pre_rs1 / rvfi_pre_rs2, output, 32 each, register values read; 0 when the index is 0.
- rvfi_post_pc, output, 32, next PC.
- rvfi_post_rd, output, 32, value written; 0 when rvfi_rd is 0.
- rvfi_post_trap, output, 1, the instruction trapped.

## Operation

- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Illegal encodings trap. This covers unsupported opcodes, bad funct3/funct7, and a shift-immediate with bit 25 set.
- Register file: 31×32 bits. x0 reads 0 and is never written.
- FSM states: FETCH → EXEC → RETIRE → FETCH. On trap, the path is RETIRE → HALT.
- FETCH:
  - imem_valid=1 and imem_addr=pc.
  - Held until imem_ready.
  - imem_addr is stable while waiting.
  - The instruction is latched on handshake.
- EXEC:
  - Decode, read rs1/rs2, compute the result and next PC.
  - Registered into the retire fields.
- RETIRE:
  - rvfi_valid=1 for this cycle only.
  - Write rd and update pc.
- Arithmetic: all modulo 2^32. Shifts use the low 5 bits. SLT is signed; SLTU is unsigned.
- Branch and JAL target = pc + imm. JALR target = (rs1 + imm) & ~1.
- Fall-through PC = pc + 4.
- Trap conditions:
  - Illegal instruction.
  - A taken branch, JAL or JALR with target[1] set.
- Trap handling:
  - rvfi_post_trap=1, rvfi_rd=0, rvfi_post_rd=0, rvfi_post_pc=pre_pc.
  - No register write.
  - Enter HALT, which does nothing further until reset.
- Unused-operand rules:
  - LUI, AUIPC and JAL report rs1=rs2=0.
  - OP-IMM and JALR report rs2=0.
  - Branches report rd=0.

## Timing

- Reset (asynchronous assert):
  - State=FETCH, pc=RESET_PC, imem_valid=0, all rvfi_* outputs=0.
  - The register file is not reset.
- First fetch request: imem_valid rises the first cycle after resetn deasserts.
- Latency: with imem_ready tied high, one instruction per 3 cycles. Each imem wait cycle adds one.
- RVFI outputs:
  - All registered.
  - Fields other than rvfi_valid keep their last values between pulses.
- Register write takes effect at the end of the RETIRE cycle and is visible to the next EXEC.
- Reset mid-fetch: the request drops immediately and asynchronously. No partial retire is emitted.
- imem_ready asserted while imem_valid=0 is ignored.

## Structure

- Shared package rvfi_mini_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, OP_IMM, OP);
  - funct3 constants;
  - the state enum (FETCH, EXEC, RETIRE, HALT);
  - an immediate-format enum (I, S, B, U, J).
- One combinational sub-module, rvfi_mini_alu:
  - inputs: operands, funct3 and alt bit;
  - outputs: result and branch condition.
- Decode, register file and FSM stay in the top module.

## Test plan

- Reset with imem_ready=1:
  - All rvfi_* outputs 0 during reset.
  - First imem_addr=RESET_PC one cycle after resetn rises.
- 0x00500093 (ADDI x1,x0,5) at 0 → rvfi_valid on cycle 3 with:
  - rs1=0, rs2=0, rd=1, post_rd=5, post_pc=4, post_trap=0.
- After x1=5 and x2=7, fetch 0x002081B3 (ADD x3,x1,x2) → pre_rs1=5, pre_rs2=7, rd=3, post_rd=12.
- 0x00000463 (BEQ x0,x0,+8) at PC 0x10 → rd=0, post_pc=0x18.
- Trap cases:
  - 0x00000000 (illegal) → post_trap=1, post_pc=pre_pc, rd=0, then no further imem_valid.
  - 0x006000EF (JAL x1,+6) → same trap response, and x1 unchanged.
- imem_ready delayed 3 cycles → imem_addr stable, retire 3 cycles later.
- resetn pulsed low during FETCH → no rvfi_valid, restart at RESET_PC.
